seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder_if.sv | 18 +
 rtl/seg7_scan_decoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed 7-segment bus in, decoded frame out
interface seg7_scan_decoder_if;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        frame_valid;
    logic        idle;
    modport master (
        output seg_n, an_n,
        input  digits, blank_mask, err_mask, frame_valid, idle
    );
    modport slave (
        input  seg_n, an_n,
        output digits, blank_mask, err_mask, frame_valid, idle
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a 4-digit frame by sniffing a multiplexed active-low 7-segment display bus
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    logic [10:0]   sample_q;
    logic [RW-1:0] run_q, run_d;
    logic [TW-1:0] noan_q, noan_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   slot_val_q, slot_val_d;
    logic [3:0]    slot_blank_q, slot_blank_d;
    logic [3:0]    slot_err_q, slot_err_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    err_q, err_d;
    logic          frame_valid_q, frame_valid_d;
    logic          idle_q, idle_d;
    logic [3:0]    sel;
    logic          one_hot;
    logic [1:0]    pos;
    logic [3:0]    dec_val;
    logic          dec_blank;
    logic          dec_err;
    logic          commit;
    logic          timeout;
    logic          load;
    // Decode the live sample: which single anode is driven and what the segments show
    always_comb begin
        sel       = ~bus.an_n;
        one_hot   = (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
        pos       = sel[0] ? 2'd0 : sel[1] ? 2'd1 : sel[2] ? 2'd2 : 2'd3;
        dec_val   = 4'hE;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (bus.seg_n)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: begin
                dec_val   = 4'hF;
                dec_blank = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end
    // Run length and no-anode counters; each fires its event only on the edge it reaches the limit
    always_comb begin
        run_d   = !one_hot ? '0
                : (run_q != '0 && sample_q == {bus.an_n, bus.seg_n}) ? (run_q == RUN_MAX ? run_q : run_q + RW'(1))
                : RW'(1);
        commit  = one_hot && run_d == RUN_MAX && run_q != RUN_MAX;
        noan_d  = bus.an_n != 4'hF ? '0 : noan_q == TO_MAX ? noan_q : noan_q + TW'(1);
        timeout = noan_d == TO_MAX && noan_q != TO_MAX;
    end
    // Slot collection and frame publication; a same-edge commit lands after the clear
    always_comb begin
        load          = seen_q == 4'hF;
        seen_d        = seen_q;
        slot_val_d    = slot_val_q;
        slot_blank_d  = slot_blank_q;
        slot_err_d    = slot_err_q;
        digits_d      = load ? slot_val_q : digits_q;
        blank_d       = load ? slot_blank_q : blank_q;
        err_d         = load ? slot_err_q : err_q;
        frame_valid_d = load;
        idle_d        = commit ? 1'b0 : timeout ? 1'b1 : idle_q;
        if (load || timeout) begin
            seen_d       = '0;
            slot_val_d   = '0;
            slot_blank_d = '0;
            slot_err_d   = '0;
        end
        if (commit) begin
            seen_d[pos]                 = 1'b1;
            slot_val_d[{pos, 2'b00} +: 4] = dec_val;
            slot_blank_d[pos]           = dec_blank;
            slot_err_d[pos]             = dec_err;
        end
    end
    // State registers with asynchronous reset; idle reads as asserted out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q      <= '0;
            run_q         <= '0;
            noan_q        <= '0;
            seen_q        <= '0;
            slot_val_q    <= '0;
            slot_blank_q  <= '0;
            slot_err_q    <= '0;
            digits_q      <= '0;
            blank_q       <= '0;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            sample_q      <= {bus.an_n, bus.seg_n};
            run_q         <= run_d;
            noan_q        <= noan_d;
            seen_q        <= seen_d;
            slot_val_q    <= slot_val_d;
            slot_blank_q  <= slot_blank_d;
            slot_err_q    <= slot_err_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
            idle_q        <= idle_d;
        end
    end
    assign bus.digits      = digits_q;
    assign bus.blank_mask  = blank_q;
    assign bus.err_mask    = err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.idle        = idle_q;
endmodule
